fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares one `FIFO_sync` instance between `N_REQ` producers. It drives the FIFO's `w_en` and `data_in` and never writes while the FIFO reports `full`. Producers get round-robin access in bounded bursts so that one busy producer cannot starve the others. It sits directly in front of the FIFO's write port. The FIFO read side stays with the consumer.

---
 rtl/fifo_wr_arbiter_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_if.sv | 30 +++
 rtl/fifo_sync.sv | 57 +++++
 rtl/fifo_wr_arbiter_rr_picker.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 102 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Holds the state encoding, the stats counter width and the index-width helper.
package fifo_arb_pkg;

    localparam int STATS_W = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = ST_IDLE,
        BURST = ST_BURST
    } arb_state_t;

    // A single producer still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO write-port bundle; master is the arbiter side, slave the producers and FIFO.
// Pure wiring: no latency, no storage.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    import fifo_arb_pkg::*;

    localparam int OWN_W = idx_w(N_REQ);

    logic [N_REQ-1:0]             req;
    logic [N_REQ-1:0][DATA_W-1:0] wdata;
    logic [N_REQ-1:0]             ack;
    logic                         fifo_full;
    logic                         fifo_w_en;
    logic [DATA_W-1:0]            fifo_data_in;
    logic [OWN_W-1:0]             owner;
    logic                         busy;

    modport master (
        input  req, wdata, fifo_full,
        output ack, fifo_w_en, fifo_data_in, owner, busy
    );

    modport slave (
        output req, wdata, fifo_full,
        input  ack, fifo_w_en, fifo_data_in, owner, busy
    );

endinterface

// File: rtl/fifo_sync.sv
// Synchronous show-ahead FIFO; data_out presents the head word, a read pops it on the edge.
// Writes are dropped while full and reads ignored while empty.
module FIFO_sync #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic              do_w;
    logic              do_r;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_w     = w_en && !full;
    assign do_r     = r_en && !empty;
    assign data_out = mem[rp];

    always_ff @(posedge clk) begin
        if (do_w) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_w) begin
                wp <= wp + 1'b1;
            end
            if (do_r) begin
                rp <= rp + 1'b1;
            end
            case ({do_w, do_r})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Round-robin picker: lowest requesting index at or after rr_ptr, wrapping.
// Purely combinational; no backpressure.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic             found,
    output logic [IW-1:0]    idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = (int'(rr_ptr) + i) % N_REQ;
            if (!found && req[j[IW-1:0]]) begin
                found = 1'b1;
                idx   = j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for one FIFO write port; grant at t+1, up to BURST_MAX words/burst.
// Stalls on fifo_full holding ownership; FIFO_ARB_STATS_EN adds saturating per-producer ack counts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                nrst,
    fifo_wr_arbiter_if.master   bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ-1:0][STATS_W-1:0] wr_count
`endif
);

    localparam int IW = idx_w(N_REQ);

    arb_state_t       state;
    logic [IW-1:0]    owner_q;
    logic [IW-1:0]    rr_ptr;
    logic [4:0]       beat_cnt;

    logic             found;
    logic [IW-1:0]    pick;
    logic [N_REQ-1:0] ack;
    logic             owner_req;
    logic             last_beat;
    logic [IW-1:0]    next_ptr;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .found  (found),
        .idx    (pick)
    );

    always_comb begin
        owner_req = bus.req[owner_q];
        last_beat = (beat_cnt == 5'(BURST_MAX - 1));
        next_ptr  = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

        // Reset gates the write strobe so an in-flight word is never committed.
        ack = '0;
        if (nrst && (state == BURST) && owner_req && !bus.fifo_full) begin
            ack[owner_q] = 1'b1;
        end
    end

    assign bus.ack          = ack;
    assign bus.fifo_w_en    = |ack;
    assign bus.fifo_data_in = (|ack) ? bus.wdata[owner_q] : '0;
    assign bus.owner        = owner_q;
    assign bus.busy         = (state == BURST);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state    <= IDLE;
            owner_q  <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner_q  <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                    end
                end
                BURST: begin
                    if (!owner_req || (|ack && last_beat)) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr;
                    end else if (|ack) begin
                        beat_cnt <= beat_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_count <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i] && (wr_count[i] != {STATS_W{1'b1}})) begin
                    wr_count[i] <= wr_count[i] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter driving a depth-8 FIFO_sync; words expected at the FIFO
// read port are queued when loaded and checked as they are read back.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic fifo_nrst = 1'b0;
    logic r_en = 1'b0;
    logic nrst_d = 1'b0;
    logic r_en_d = 1'b0;

    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

    logic [DW-1:0] f_dout;
    logic          f_full;
    logic          f_empty;
    logic [3:0]    f_count;

    FIFO_sync #(.DATA_W(DW), .DEPTH(8)) u_fifo (
        .clk      (clk),
        .nrst     (fifo_nrst),
        .w_en     (bus.fifo_w_en),
        .r_en     (r_en),
        .data_in  (bus.fifo_data_in),
        .data_out (f_dout),
        .full     (f_full),
        .empty    (f_empty),
        .count    (f_count)
    );

    assign bus.fifo_full = f_full;

`ifdef FIFO_ARB_STATS_EN
    logic [N-1:0][STATS_W-1:0] wr_count;
`endif

    fifo_wr_arbiter #(.N_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.master)
`ifdef FIFO_ARB_STATS_EN
        ,
        .wr_count (wr_count)
`endif
    );

    logic [DW-1:0] pdata [N][16];
    int            phead [N];
    int            ptail [N];
    logic [N-1:0]  pend_ack;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_w;
    int            n_assert = 0;
    int            n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: retire last cycle's acks, drive inputs after the edge, sample at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pend_ack[i]) phead[i]++;
        end
        nrst = nrst_d;
        r_en = r_en_d;
        for (int i = 0; i < N; i++) begin
            bus.req[i]   = (phead[i] != ptail[i]);
            bus.wdata[i] = (phead[i] != ptail[i]) ? pdata[i][phead[i]] : '0;
        end
        @(negedge clk);
        pend_ack = bus.ack;
        if (bus.fifo_w_en) chk("w_en_while_full", 32'(f_full), 32'(0));
        if (r_en && !f_empty) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'(exp_q.size()), 32'(1));
            end else begin
                exp_w = exp_q.pop_front();
                chk("fifo_rd_data", 32'(f_dout), 32'(exp_w));
            end
        end
    endtask

    task automatic load(input int p, input logic [DW-1:0] base, input int n, input bit push_exp);
        for (int k = 0; k < n; k++) begin
            pdata[p][ptail[p]] = base + DW'(k);
            ptail[p]++;
            if (push_exp) exp_q.push_back(base + DW'(k));
        end
    endtask

    task automatic reset_all();
        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        pend_ack = '0;
        r_en_d = 1'b0;
        nrst_d = 1'b0;
        tick();
        tick();
        nrst_d = 1'b1;
    endtask

    task automatic drain();
        r_en_d = 1'b1;
        for (int k = 0; k < 60 && exp_q.size() != 0; k++) tick();
        chk("drain_sb_empty", 32'(exp_q.size()), 32'(0));
        r_en_d = 1'b0;
        tick();
        chk("drain_fifo_count", 32'(f_count), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : seq
        int total;
        int bursts_done;
        int beats;
        int idle_run;
        logic prev_busy;
        logic [N-1:0] exp_ack;

        bus.req   = '0;
        bus.wdata = '0;
        for (int i = 0; i < N; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        pend_ack = '0;

        // Reset values
        tick();
        tick();
        chk("rst_ack", 32'(bus.ack), 32'(0));
        chk("rst_w_en", 32'(bus.fifo_w_en), 32'(0));
        chk("rst_data_in", 32'(bus.fifo_data_in), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_owner", 32'(bus.owner), 32'(0));
        fifo_nrst = 1'b1;
        nrst_d = 1'b1;
        tick();
        chk("rst_rr_ptr", 32'(dut.rr_ptr), 32'(0));
        chk("rst_beat_cnt", 32'(dut.beat_cnt), 32'(0));

        // Single producer: acks at t+1..t+4 and t+6..t+7
        load(1, 8'h10, 6, 1'b1);
        for (int k = 0; k < 10; k++) begin
            tick();
            exp_ack = ((k >= 1 && k <= 4) || (k >= 6 && k <= 7)) ? 4'b0010 : 4'b0000;
            chk($sformatf("s1_ack_t%0d", k), 32'(bus.ack), 32'(exp_ack));
            if (k == 5) chk("s1_busy_t5", 32'(bus.busy), 32'(0));
        end
`ifdef FIFO_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk($sformatf("stats_wr_count_%0d", i), 32'(wr_count[i]), (i == 1) ? 32'd6 : 32'd0);
        end
`endif
        drain();

        // Round-robin with all producers busy
        reset_all();
        r_en_d = 1'b1;
        for (int p = 0; p < N; p++) load(p, 8'(8'h40 * p), 8, 1'b0);
        for (int b = 0; b < 8; b++) begin
            for (int w = 0; w < BM; w++) exp_q.push_back(8'(8'h40 * (b % N) + (b / N) * BM + w));
        end
        bursts_done = 0;
        beats = 0;
        idle_run = 0;
        prev_busy = 1'b0;
        for (int k = 0; k < 80 && bursts_done < 8; k++) begin
            tick();
            if (bus.busy) begin
                if (!prev_busy) begin
                    if (bursts_done > 0) chk("s2_idle_gap", 32'(idle_run), 32'(1));
                    chk("s2_owner", 32'(bus.owner), 32'(bursts_done % N));
                    beats = 0;
                end
                chk("s2_ack", 32'(bus.ack), 32'(4'b0001 << (bursts_done % N)));
                if (bus.ack != '0) beats++;
                idle_run = 0;
            end else begin
                if (prev_busy) begin
                    chk("s2_beats", 32'(beats), 32'(BM));
                    bursts_done++;
                end
                idle_run++;
            end
            prev_busy = bus.busy;
        end
        chk("s2_bursts", 32'(bursts_done), 32'(8));
        drain();

        // Full stall
        reset_all();
        load(2, 8'hA0, 9, 1'b1);
        total = 0;
        for (int k = 0; k < 40 && total < 8; k++) begin
            tick();
            if (bus.ack != '0) total++;
        end
        chk("s3_acks_to_full", 32'(total), 32'(8));
        tick();
        tick();
        chk("s3_full", 32'(f_full), 32'(1));
        chk("s3_ack", 32'(bus.ack), 32'(0));
        chk("s3_w_en", 32'(bus.fifo_w_en), 32'(0));
        chk("s3_busy", 32'(bus.busy), 32'(1));
        chk("s3_owner", 32'(bus.owner), 32'(2));
        tick();
        chk("s3_hold_busy", 32'(bus.busy), 32'(1));
        chk("s3_hold_ack", 32'(bus.ack), 32'(0));
        r_en_d = 1'b1;
        tick();
        r_en_d = 1'b0;
        total = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.ack != '0) total++;
        end
        chk("s3_one_ack_after_pulse", 32'(total), 32'(1));
        drain();

        // Early release
        reset_all();
        r_en_d = 1'b1;
        load(3, 8'hC0, 2, 1'b1);
        tick();
        chk("s4_ack_t0", 32'(bus.ack), 32'(0));
        tick();
        chk("s4_ack_t1", 32'(bus.ack), 32'(4'b1000));
        load(0, 8'h30, 2, 1'b1);
        tick();
        chk("s4_ack_t2", 32'(bus.ack), 32'(4'b1000));
        tick();
        chk("s4_drop_ack", 32'(bus.ack), 32'(0));
        tick();
        chk("s4_idle_busy", 32'(bus.busy), 32'(0));
        chk("s4_rr_ptr", 32'(dut.rr_ptr), 32'(0));
        tick();
        chk("s4_owner", 32'(bus.owner), 32'(0));
        chk("s4_first_ack", 32'(bus.ack), 32'(4'b0001));
        drain();

        // Reset mid-burst
        reset_all();
        load(1, 8'h50, 4, 1'b1);
        tick();
        tick();
        tick();
        nrst_d = 1'b0;
        tick();
        chk("s5_rst_ack", 32'(bus.ack), 32'(0));
        chk("s5_rst_w_en", 32'(bus.fifo_w_en), 32'(0));
        chk("s5_count_before", 32'(f_count), 32'(2));
        nrst_d = 1'b1;
        tick();
        chk("s5_state", 32'(dut.state), 32'(IDLE));
        chk("s5_busy", 32'(bus.busy), 32'(0));
        chk("s5_owner", 32'(bus.owner), 32'(0));
        chk("s5_rr_ptr", 32'(dut.rr_ptr), 32'(0));
        chk("s5_count_after", 32'(f_count), 32'(2));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
